hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard scoreboard with per-register in-flight write counters.
// Optional write-back bypass enabled by defining HAZARD_WB_BYPASS_EN.
module hazard_scoreboard #(
  parameter int unsigned CNT_W       = 2,
  parameter int unsigned STALL_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [19:0]            instruction,
  input  logic                   id_valid,
  input  logic                   wb_valid,
  input  logic [3:0]             wb_addr,
  output logic                   stall,
  output logic                   issue,
  output logic                   pc_write_en,
  output logic                   ifid_write_en,
  output logic                   idex_bubble,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] PendMax = '1;
  localparam logic [CNT_W-1:0] PendOne = CNT_W'(1);

  logic [CNT_W-1:0]       pend_q [16];
  logic [CNT_W-1:0]       pend_d [16];
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic [3:0]  opcode, src_a, src_b, dst;
  logic        is_nop, is_store, uses_src, has_dst;
  logic        conf_a, conf_b, dst_full;
  logic        inc_en, dec_en;
  logic [15:0] inc_vec, dec_vec;

  // Instruction decode: STORE reads [15:12]/[11:8], everything else reads [11:8]/[7:4].
  always_comb begin
    opcode   = instruction[19:16];
    is_nop   = (opcode == 4'b0000);
    is_store = (opcode == 4'b1100);
    uses_src = ~is_nop;
    has_dst  = ~is_nop & ~is_store;
    src_a    = is_store ? instruction[15:12] : instruction[11:8];
    src_b    = is_store ? instruction[11:8]  : instruction[7:4];
    dst      = instruction[15:12];
  end

  always_comb begin
    conf_a = (pend_q[src_a] != '0);
    conf_b = (pend_q[src_b] != '0);
`ifdef HAZARD_WB_BYPASS_EN
    // Last outstanding write lands in the register file this cycle.
    if (wb_valid && (wb_addr == src_a) && (pend_q[src_a] == PendOne)) conf_a = 1'b0;
    if (wb_valid && (wb_addr == src_b) && (pend_q[src_b] == PendOne)) conf_b = 1'b0;
`endif
    dst_full = (pend_q[dst] == PendMax);
  end

  always_comb begin
    stall         = id_valid & ~reset & ((uses_src & (conf_a | conf_b)) | (has_dst & dst_full));
    issue         = id_valid & ~stall;
    pc_write_en   = ~stall;
    ifid_write_en = ~stall;
    idex_bubble   = stall;
    stall_count   = stall_count_q;
  end

  always_comb begin
    inc_en  = issue & has_dst;
    dec_en  = wb_valid & (pend_q[wb_addr] != '0);
    inc_vec = inc_en ? (16'h0001 << dst) : 16'h0000;
    dec_vec = dec_en ? (16'h0001 << wb_addr) : 16'h0000;
    for (int r = 0; r < 16; r++) begin
      pend_d[r] = pend_q[r];
      // A coincident increment and decrement on one register cancel out.
      if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + PendOne;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        pend_d[r] = pend_q[r] - PendOne;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 16; r++) begin
        pend_q[r] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < 16; r++) begin
        pend_q[r] <= pend_d[r];
      end
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus random traffic
// checked against a counter-array reference model.
module tb_hazard_scoreboard;

  localparam int unsigned CNT_W       = 2;
  localparam int unsigned STALL_CNT_W = 8;
  localparam int          PendMax     = (1 << CNT_W) - 1;
  localparam int          ScMax       = (1 << STALL_CNT_W) - 1;
`ifdef HAZARD_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset;
  logic [19:0]            instruction;
  logic                   id_valid, wb_valid;
  logic [3:0]             wb_addr;
  logic                   stall, issue, pc_write_en, ifid_write_en, idex_bubble;
  logic [STALL_CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_fails  = 0;
  int pend_m [16];
  int sc_m;

  hazard_scoreboard #(
    .CNT_W      (CNT_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .id_valid     (id_valid),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .stall        (stall),
    .issue        (issue),
    .pc_write_en  (pc_write_en),
    .ifid_write_en(ifid_write_en),
    .idex_bubble  (idex_bubble),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: list of register sources and optional destination.
  function automatic void decode(input logic [19:0] ins, output int nsrc, output int s0,
                                 output int s1, output bit hd, output int d);
    int op = int'(ins[19:16]);
    d  = int'(ins[15:12]);
    s0 = 0;
    s1 = 0;
    if (op == 0) begin
      nsrc = 0; hd = 0;
    end else if (op == 12) begin
      nsrc = 2; hd = 0; s0 = int'(ins[15:12]); s1 = int'(ins[11:8]);
    end else begin
      nsrc = 2; hd = 1; s0 = int'(ins[11:8]); s1 = int'(ins[7:4]);
    end
  endfunction

  function automatic bit src_blocks(input int s, input bit wbv, input int wba);
    if (pend_m[s] == 0) return 0;
    if (Bypass && wbv && wba == s && pend_m[s] == 1) return 0;
    return 1;
  endfunction

  function automatic bit model_stall(input logic [19:0] ins, input bit idv, input bit wbv,
                                     input int wba, input bit rst);
    int nsrc, s0, s1, d;
    bit hd;
    if (!idv || rst) return 0;
    decode(ins, nsrc, s0, s1, hd, d);
    if (nsrc > 0 && (src_blocks(s0, wbv, wba) || src_blocks(s1, wbv, wba))) return 1;
    if (hd && pend_m[d] == PendMax) return 1;
    return 0;
  endfunction

  // One clock cycle: drive, check combinational outputs, then advance the model at the edge.
  task automatic step(input bit rst, input logic [19:0] ins, input bit idv, input bit wbv,
                      input logic [3:0] wba);
    bit exp_stall, dec_ok;
    int nsrc, s0, s1, d;
    bit hd;
    reset = rst; instruction = ins; id_valid = idv; wb_valid = wbv; wb_addr = wba;
    #1;
    exp_stall = model_stall(ins, idv, wbv, int'(wba), rst);
    check("stall", 32'(stall), 32'(exp_stall));
    check("issue", 32'(issue), 32'(idv && !exp_stall));
    check("pc_write_en", 32'(pc_write_en), 32'(!exp_stall));
    check("ifid_write_en", 32'(ifid_write_en), 32'(!exp_stall));
    check("idex_bubble", 32'(idex_bubble), 32'(exp_stall));
    check("stall_count", 32'(stall_count), 32'(sc_m));
    @(posedge clock);
    if (rst) begin
      foreach (pend_m[r]) pend_m[r] = 0;
      sc_m = 0;
    end else begin
      decode(ins, nsrc, s0, s1, hd, d);
      dec_ok = wbv && pend_m[wba] > 0;
      if (exp_stall && sc_m < ScMax) sc_m++;
      if (idv && !exp_stall && hd) pend_m[d]++;
      if (dec_ok) pend_m[wba]--;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 20'h0, 0, 0, 4'h0);
  endtask

  task automatic do_reset();
    step(1, 20'h1_3_12_0, 1, 0, 4'h0);
  endtask

  initial begin
    logic [31:0] r;
    logic [19:0] ins;
    foreach (pend_m[i]) pend_m[i] = 0;
    sc_m = 0;
    reset = 1'b1; instruction = '0; id_valid = 0; wb_valid = 0; wb_addr = '0;
    @(posedge clock);
    @(negedge clock);

    // Outputs while reset is held, with a valid instruction present.
    do_reset();
    do_reset();
    idle();

    // RAW stall on r3, then release by write-back of r3.
    step(0, 20'h1_3_12_0, 1, 0, 4'h0);
    step(0, 20'h2_5_34_0, 1, 0, 4'h0);
    step(0, 20'h2_5_34_0, 1, 0, 4'h0);
    step(0, 20'h2_5_34_0, 1, 1, 4'h3);
    step(0, 20'h2_5_34_0, 1, 0, 4'h0);
    step(0, 20'h0, 0, 1, 4'h5);

    // STORE reads [15:12] and [11:8].
    do_reset();
    step(0, 20'h1_7_00_0, 1, 0, 4'h0);
    step(0, 20'hC_7_20_0, 1, 0, 4'h0);
    do_reset();
    step(0, 20'h1_0_55_0, 1, 0, 4'h0);
    step(0, 20'hC_7_20_0, 1, 0, 4'h0);

    // Counter saturation on r9 and simultaneous issue + write-back on r9.
    do_reset();
    repeat (4) step(0, 20'h1_9_00_0, 1, 0, 4'h0);
    step(0, 20'h0, 0, 1, 4'h9);
    step(0, 20'h1_9_00_0, 1, 1, 4'h9);
    step(0, 20'h1_9_00_0, 1, 0, 4'h0);
    step(0, 20'h1_9_00_0, 1, 0, 4'h0);

    // Underflow ignored; reset clears counters mid-flight.
    do_reset();
    step(0, 20'h0, 0, 1, 4'h4);
    step(0, 20'h2_5_44_0, 1, 0, 4'h0);
    step(0, 20'h1_1_00_0, 1, 0, 4'h0);
    step(0, 20'h1_1_00_0, 1, 0, 4'h0);
    step(0, 20'h2_2_11_0, 1, 0, 4'h0);
    do_reset();
    step(0, 20'h2_2_11_0, 1, 1, 4'h1);
    step(0, 20'h2_2_11_0, 1, 0, 4'h0);

    // stall_count saturation over a 300-cycle hold.
    do_reset();
    step(0, 20'h1_1_00_0, 1, 0, 4'h0);
    repeat (300) step(0, 20'h2_2_11_0, 1, 0, 4'h0);
    step(0, 20'h2_2_11_0, 1, 1, 4'h1);
    idle();

    // Random traffic over a small register subset to provoke hazards.
    do_reset();
    repeat (600) begin
      r   = $urandom();
      ins = {r[13:10], 2'b00, r[1:0], 2'b00, r[3:2], 2'b00, r[5:4], 4'h0};
      step(r[31:27] == 5'd0, ins, r[8] | r[9], r[20] | r[21], {2'b00, r[7:6]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
